// File: rtl/serpent_pipe_scheduler_if.sv
// Block-stream handshake bundle between the system source/sink and the scheduler.
// master = system side, slave = scheduler side.
interface serpent_pipe_scheduler_if #(
  parameter int unsigned TAG_W = 8
) ();
  logic             s_valid;
  logic             s_ready;
  logic [127:0]     s_data;
  logic [TAG_W-1:0] s_tag;
  logic             m_valid;
  logic             m_ready;
  logic [127:0]     m_data;
  logic [TAG_W-1:0] m_tag;

  modport master (
    output s_valid, s_data, s_tag, m_ready,
    input  s_ready, m_valid, m_data, m_tag
  );

  modport slave (
    input  s_valid, s_data, s_tag, m_ready,
    output s_ready, m_valid, m_data, m_tag
  );
endinterface

// File: rtl/serpent_pipe_scheduler.sv
// Flow-control wrapper for a free-running fixed-latency Serpent core: valid/tag shadow
// pipeline, credit-admitted output FIFO and an enable/drain state machine.
module serpent_pipe_scheduler #(
  parameter int unsigned LATENCY    = 17,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned TAG_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  serpent_pipe_scheduler_if.slave     bus,
  output logic [127:0]                core_din,
  input  logic [127:0]                core_dout,
  output logic [$clog2(FIFO_DEPTH):0] occupancy,
  output logic                        drained
);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW = PtrW + 1;
  localparam int unsigned EntW = 128 + TAG_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [PtrW:0]   PtrOne  = 1;
  localparam logic [OccW-1:0] OccOne  = 1;
  localparam logic [OccW-1:0] OccFull = OccW'(FIFO_DEPTH);

  logic [1:0]         state_q, state_d;
  logic [LATENCY-1:0] vsr_q, vsr_d;
  logic [TAG_W-1:0]   tsr_q [LATENCY];
  logic [TAG_W-1:0]   tsr_d [LATENCY];
  logic [PtrW:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]      rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]    occ_q, occ_d;
  logic [EntW-1:0]    mem_q [FIFO_DEPTH];

  logic            s_ready;
  logic            accept;
  logic            pop;
  logic            fifo_wr;
  logic            fifo_empty;
  logic [EntW-1:0] head;

  // Credits count in-flight blocks too, so every accepted block has a FIFO slot reserved.
  always_comb begin
    s_ready    = (state_q == StRun) && (occ_q < OccFull);
    accept     = bus.s_valid && s_ready;
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    pop        = !fifo_empty && bus.m_ready;
    fifo_wr    = vsr_q[LATENCY-1];
    head       = mem_q[rd_ptr_q[PtrW-1:0]];

    bus.s_ready = s_ready;
    bus.m_valid = !fifo_empty;
    bus.m_data  = fifo_empty ? '0 : head[EntW-1:TAG_W];
    bus.m_tag   = fifo_empty ? '0 : head[TAG_W-1:0];
    core_din    = accept ? bus.s_data : '0;
    occupancy   = occ_q;
    drained     = (state_q == StDrain) && (occ_q == '0);
  end

  always_comb begin
    vsr_d    = {vsr_q[LATENCY-2:0], accept};
    tsr_d[0] = accept ? bus.s_tag : '0;
    for (int i = 1; i < LATENCY; i++) begin
      tsr_d[i] = tsr_q[i-1];
    end

    wr_ptr_d = fifo_wr ? wr_ptr_q + PtrOne : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrOne : rd_ptr_q;

    occ_d = occ_q;
    unique case ({accept, pop})
      2'b10:   occ_d = occ_q + OccOne;
      2'b01:   occ_d = occ_q - OccOne;
      default: occ_d = occ_q;
    endcase

    state_d = state_q;
    case (state_q)
      StIdle:  if (enable) state_d = StRun;
      StRun:   if (!enable) state_d = StDrain;
      StDrain: if (occ_q == '0) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      vsr_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tsr_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      vsr_q    <= vsr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      for (int i = 0; i < LATENCY; i++) begin
        tsr_q[i] <= tsr_d[i];
      end
    end
  end

  // Storage needs no reset: only entries between the pointers are ever read out.
  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_q[wr_ptr_q[PtrW-1:0]] <= {core_dout, tsr_q[LATENCY-1]};
    end
  end
endmodule

// File: tb/tb_serpent_pipe_scheduler.sv
// Directed bench for serpent_pipe_scheduler with a stand-in 17-cycle core and a
// per-cycle scoreboard of accepted blocks and occupancy.
module tb_serpent_pipe_scheduler;
  localparam int unsigned Lat   = 17;
  localparam int unsigned Depth = 32;
  localparam int unsigned TagW  = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [127:0] core_din;
  logic [127:0] core_dout;
  logic [5:0]   occupancy;
  logic         drained;

  serpent_pipe_scheduler_if #(.TAG_W(TagW)) bus ();

  serpent_pipe_scheduler #(
    .LATENCY   (Lat),
    .FIFO_DEPTH(Depth),
    .TAG_W     (TagW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .bus      (bus),
    .core_din (core_din),
    .core_dout(core_dout),
    .occupancy(occupancy),
    .drained  (drained)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] core_f(input logic [127:0] x);
    return {x[120:0], x[127:121]} ^ 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  endfunction

  // Stand-in core: input register plus 16 stages, no reset, no stall.
  logic [127:0] pipe [Lat];
  always @(posedge clk) begin
    pipe[0] <= core_f(core_din);
    for (int i = 1; i < Lat; i++) pipe[i] <= pipe[i-1];
  end
  assign core_dout = pipe[Lat-1];

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int failures = 0;
  logic [135:0] exp_q[$];
  int pop_cyc_q[$];
  int n_acc = 0;
  int n_drained = 0;
  int drained_cyc = -1;
  int last_pop_cyc = -1;
  int occ_model = 0;

  task automatic chk(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic monitor();
    if (!rst_n) begin
      exp_q.delete();
      occ_model = 0;
    end else begin
      chk("occupancy_model", 136'(occupancy), 136'(occ_model));
      chk("fifo_no_overflow", 136'(occupancy <= 6'(Depth)), 136'(1));
      if (bus.s_valid && bus.s_ready) begin
        exp_q.push_back({core_f(bus.s_data), bus.s_tag});
        n_acc++;
        occ_model++;
      end
      if (bus.m_valid && bus.m_ready) begin
        chk("pop_has_expected", 136'(exp_q.size() > 0), 136'(1));
        if (exp_q.size() > 0) chk("out_block", {bus.m_data, bus.m_tag}, exp_q.pop_front());
        occ_model--;
        pop_cyc_q.push_back(cycle);
        last_pop_cyc = cycle;
      end
      if (drained) begin
        n_drained++;
        drained_cyc = cycle;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_m(input int limit, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < limit; i++) begin
      if (bus.m_valid) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    int c0;
    int hs;
    int n0;
    bit hit;
    logic [127:0] d;

    rst_n = 1'b0; enable = 1'b0; bus.m_ready = 1'b0;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_tag = '0;
    tick(); tick();
    chk("rst_s_ready", 136'(bus.s_ready), 136'(0));
    chk("rst_m_valid", 136'(bus.m_valid), 136'(0));
    chk("rst_drained", 136'(drained), 136'(0));
    chk("rst_occupancy", 136'(occupancy), 136'(0));
    chk("rst_m_data_tag", {bus.m_data, bus.m_tag}, 136'(0));
    rst_n = 1'b1;
    tick();
    chk("idle_s_ready", 136'(bus.s_ready), 136'(0));
    enable = 1'b1; bus.m_ready = 1'b1;
    tick();
    chk("run_s_ready", 136'(bus.s_ready), 136'(1));

    // Single block
    d = 128'hDEAD_BEEF_0011_2233_4455_6677_8899_AABB;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_tag = 8'h5A;
    #1;
    chk("core_din_accept", 136'(core_din), 136'(d));
    c0 = cycle;
    tick();
    bus.s_valid = 1'b0;
    #1;
    chk("core_din_idle", 136'(core_din), 136'(0));
    chk("single_occ", 136'(occupancy), 136'(1));
    wait_m(40, hit);
    chk("single_seen", 136'(hit), 136'(1));
    chk("single_latency", 136'(cycle - c0), 136'(18));
    chk("single_data", 136'(bus.m_data), 136'(core_f(d)));
    chk("single_tag", 136'(bus.m_tag), 136'(8'h5A));
    tick();
    chk("single_occ_after", 136'(occupancy), 136'(0));
    chk("single_m_valid_after", 136'(bus.m_valid), 136'(0));

    // Streaming, 40 back-to-back
    pop_cyc_q.delete(); c0 = cycle; hs = 0;
    for (int i = 0; i < 40; i++) begin
      bus.s_valid = 1'b1; bus.s_data = {4{32'(i) * 32'h9E37_79B9}}; bus.s_tag = 8'(i);
      if (bus.s_ready) hs++;
      tick();
    end
    bus.s_valid = 1'b0;
    chk("stream_ready_cycles", 136'(hs), 136'(40));
    for (int i = 0; i < 60 && pop_cyc_q.size() < 40; i++) tick();
    chk("stream_pop_count", 136'(pop_cyc_q.size()), 136'(40));
    for (int i = 0; i < 40 && i < pop_cyc_q.size(); i++)
      chk("stream_pop_cycle", 136'(pop_cyc_q[i] - c0), 136'(18 + i));
    chk("stream_all_out", 136'(exp_q.size()), 136'(0));

    // Backpressure
    bus.m_ready = 1'b0; hs = 0;
    for (int i = 0; i < 60; i++) begin
      bus.s_valid = 1'b1; bus.s_data = {4{32'(i) ^ 32'hC3C3_5A5A}}; bus.s_tag = 8'(8'h40 + i);
      if (bus.s_ready) hs++;
      tick();
    end
    chk("bp_handshakes", 136'(hs), 136'(32));
    chk("bp_s_ready_full", 136'(bus.s_ready), 136'(0));
    chk("bp_occupancy", 136'(occupancy), 136'(32));
    chk("bp_m_valid", 136'(bus.m_valid), 136'(1));
    bus.s_valid = 1'b0; bus.m_ready = 1'b1; pop_cyc_q.delete();
    chk("bp_no_credit_same_cycle", 136'(bus.s_ready), 136'(0));
    tick();
    chk("bp_ready_after_pop", 136'(bus.s_ready), 136'(1));
    for (int i = 0; i < 60 && pop_cyc_q.size() < 32; i++) tick();
    chk("bp_pop_count", 136'(pop_cyc_q.size()), 136'(32));
    chk("bp_all_out", 136'(exp_q.size()), 136'(0));
    chk("bp_occ_empty", 136'(occupancy), 136'(0));

    // Drain
    n0 = n_acc; n_drained = 0; drained_cyc = -1;
    for (int i = 0; i < 10; i++) begin
      bus.s_valid = 1'b1; bus.s_data = {4{32'(100 + i)}}; bus.s_tag = 8'(100 + i);
      if (i == 9) enable = 1'b0;
      tick();
    end
    chk("drain_s_ready", 136'(bus.s_ready), 136'(0));
    for (int i = 0; i < 60 && n_drained == 0; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    chk("drain_accepts", 136'(n_acc - n0), 136'(10));
    chk("drain_pulses", 136'(n_drained), 136'(1));
    chk("drain_pulse_cycle", 136'(drained_cyc - last_pop_cyc), 136'(1));
    chk("drain_all_out", 136'(exp_q.size()), 136'(0));
    chk("drain_occ", 136'(occupancy), 136'(0));
    bus.s_valid = 1'b0; enable = 1'b1;
    tick();
    chk("idle_reenable", 136'(bus.s_ready), 136'(1));

    // Reset mid-flight
    for (int i = 0; i < 5; i++) begin
      bus.s_valid = 1'b1; bus.s_data = {4{32'hC0DE_0000 + 32'(i)}}; bus.s_tag = 8'(8'hC0 + i);
      tick();
    end
    bus.s_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_mid_occ", 136'(occupancy), 136'(0));
    hit = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.m_valid) hit = 1'b1;
      tick();
    end
    chk("rst_mid_no_ghost", 136'(hit), 136'(0));
    chk("rst_mid_occ_after", 136'(occupancy), 136'(0));
    d = 128'hFACE_0000_1111_2222_3333_4444_5555_6666;
    bus.s_valid = 1'b1; bus.s_data = d; bus.s_tag = 8'h77;
    chk("rst_mid_ready", 136'(bus.s_ready), 136'(1));
    c0 = cycle;
    tick();
    bus.s_valid = 1'b0;
    wait_m(40, hit);
    chk("rst_mid_seen", 136'(hit), 136'(1));
    chk("rst_mid_latency", 136'(cycle - c0), 136'(18));
    chk("rst_mid_data", 136'(bus.m_data), 136'(core_f(d)));
    chk("rst_mid_tag", 136'(bus.m_tag), 136'(8'h77));
    tick();

    // Random traffic
    n0 = n_acc;
    for (int i = 0; i < 2000; i++) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) enable = ~enable;
      bus.s_data = {$urandom, $urandom, $urandom, $urandom};
      bus.s_tag = 8'(i);
      tick();
    end
    bus.s_valid = 1'b0; bus.m_ready = 1'b1; enable = 1'b0;
    for (int i = 0; i < 100 && (occupancy != 0 || bus.m_valid); i++) tick();
    tick();
    chk("rand_some_accepts", 136'(n_acc > n0), 136'(1));
    chk("rand_no_loss", 136'(exp_q.size()), 136'(0));
    chk("rand_occ_empty", 136'(occupancy), 136'(0));
    chk("rand_m_valid_empty", 136'(bus.m_valid), 136'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serpent_pipe_scheduler.md
Name: serpent_pipe_scheduler

Overview:
Flow-control wrapper for the free-running 16-stage Serpent encryption core. The core has 17-cycle latency, no stall input and no valid signal. This block adds:
- a valid/ready input stream,
- an in-flight valid/tag shift register matched to the core latency,
- an output FIFO with credit-based admission, so output backpressure never drops a block,
- an enable/drain state machine.
It sits between the system's block-stream source/sink and one core instance.

Parameters:
LATENCY, 17, cycles from core_din sampled to result on core_dout (1 input register + 16 stages).
FIFO_DEPTH, 32, output FIFO entries; power of two; must be >= LATENCY.
TAG_W, 8, user tag width carried alongside each block.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
enable  in  1  1 = accept new blocks; 0 = stop accepting and drain
s_valid  in  1  input block valid
s_ready  out  1  block accepted when s_valid && s_ready
s_data  in  128  plaintext block
s_tag  in  TAG_W  tag returned with the ciphertext
core_din  out  128  to core data_in
core_dout  in  128  from core data_out
m_valid  out  1  output block valid (FIFO not empty)
m_ready  in  1  sink accepts when m_valid && m_ready
m_data  out  128  ciphertext at FIFO head
m_tag  out  TAG_W  tag at FIFO head
occupancy  out  $clog2(FIFO_DEPTH)+1  blocks in flight plus blocks in FIFO
drained  out  1  one-cycle pulse on DRAIN->IDLE

Behaviour:
- Reset (async assert, sync release) clears:
  - state to IDLE
  - valid shift register, FIFO pointers and occ counter to 0
  - outputs: s_ready=0, m_valid=0, drained=0, occupancy=0; m_data/m_tag=0.
- Core pipeline registers are not reset. Blocks in flight at reset are discarded and never surface, because their valid bits are cleared.
- FSM:
  - IDLE -> RUN when enable=1.
  - RUN -> DRAIN when enable=0.
  - DRAIN -> IDLE when occ==0; drained=1 for that transition cycle only.
  - DRAIN ignores enable until it reaches IDLE.
- s_ready = (state==RUN) && (occ < FIFO_DEPTH). It is combinational from registered state. A same-cycle output pop does not free a credit.
- core_din = s_data when accepting this cycle, else 128'h0.
- Accept in cycle t:
  - vsr[0] and tsr[0] load at the edge ending cycle t.
  - Shift registers advance every cycle, unconditionally.
  - vsr[LATENCY-1]=1 in cycle t+LATENCY, aligned with core_dout.
  - In that cycle, {core_dout, tsr[LATENCY-1]} is written to the FIFO.
- Minimum latency is s handshake in cycle t to m_valid=1 in cycle t+LATENCY+1 (18 by default).
- The FIFO is show-ahead: m_data/m_tag reflect the head while m_valid=1, and hold stable until the handshake.
- The FIFO never overflows, by construction from the credit rule. An assertion in the bench checks this.
- occ counting:
  - +1 on input handshake, -1 on output handshake.
  - Both in the same cycle leave it unchanged.
  - occupancy = occ.
- Ordering is strictly FIFO; tags are preserved.
- Throughput is 1 block/cycle sustained when m_ready=1 and FIFO_DEPTH >= LATENCY+1.
- enable dropping mid-burst: the cycle enable is seen low, s_ready still reflects the current state (RUN). From the next cycle s_ready=0. All accepted blocks still emerge.
- Empty/full:
  - m_valid=0 when the FIFO is empty, even if blocks are in flight.
  - occ==FIFO_DEPTH forces s_ready=0.

Test Plan:
- Single block: reset, enable=1, one block with tag 8'h5A in cycle 0, m_ready=1 -> m_valid first high in cycle 18 with m_data equal to the golden model and m_tag=8'h5A. occupancy returns 0 after the handshake.
- Streaming: 40 back-to-back blocks with tags 0..39, m_ready=1 -> s_ready never drops, outputs in cycles 18..57 contiguous, tags in order, all data matches the model.
- Backpressure: m_ready=0, s_valid held high -> exactly 32 handshakes, then s_ready=0. occupancy=32, m_valid=1. Release m_ready -> 32 outputs in order; s_ready reasserts the cycle after the first pop.
- Drain: 10 blocks accepted, then enable=0 -> s_ready=0 the next cycle, all 10 outputs emerge, drained pulses exactly once when occ reaches 0, state returns to IDLE. No accepts occur while in DRAIN.
- Reset mid-flight: 5 blocks accepted, rst_n low 2 cycles in cycle 8 -> m_valid stays 0 for 40 cycles afterwards and occupancy=0. A fresh block after re-enable returns correctly at +18.
- Random: 2000 cycles of random s_valid/m_ready/enable toggles -> scoreboard has no loss, no duplicates, order and tags correct, FIFO-overflow assertion never fires.
